// File: rtl/slot_pkg.sv
// Shared types and constants for the slot-machine credit controller.
package slot_pkg;

    localparam int DEF_SCORE_W = 17;
    localparam logic [DEF_SCORE_W-1:0] CREDIT_MAX = {DEF_SCORE_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SPIN   = 2'd1,
        PAYOUT = 2'd2
    } state_e;

endpackage

// File: rtl/sat_adder.sv
// Three-operand unsigned adder that clamps at 2^W-1 instead of wrapping.
module sat_adder #(
    parameter int W = 17
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic [W-1:0] c_i,
    output logic [W-1:0] sum_o
);

    localparam logic [W-1:0] MAXV = {W{1'b1}};

    // Two guard bits hold any carry from three W-bit operands.
    logic [W+1:0] sum_w;

    // Full-width sum, then clamp if any guard bit is set.
    always_comb begin
        sum_w = {2'b00, a_i} + {2'b00, b_i} + {2'b00, c_i};
        sum_o = (sum_w[W+1:W] != 2'b00) ? MAXV : sum_w[W-1:0];
    end

endmodule

// File: rtl/slot_credit_ctrl.sv
// Slot-machine credit controller: debits bets, hands off to the reels,
// credits the payout and accepts coins, all with saturating arithmetic.
module slot_credit_ctrl
    import slot_pkg::*;
#(
    parameter int SCORE_W     = slot_pkg::DEF_SCORE_W,
    parameter int SINGLE_BET  = 1,
    parameter int MAX_BET     = 5,
    parameter int MULT_W      = 4,
    parameter int INIT_CREDIT = 100,
    parameter int COIN_VALUE  = 1
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               bet_req,
    input  logic               max_sel,
    input  logic               coin_in,
    input  logic               spin_done,
    input  logic [MULT_W-1:0]  payout_mult,
    output logic [SCORE_W-1:0] credit,
    output logic [SCORE_W-1:0] bet_amount,
    output logic               spin_start,
    output logic               busy,
    output logic               insufficient,
    output logic               win_pulse,
    output logic [SCORE_W-1:0] last_payout
);

    localparam int PW = SCORE_W + MULT_W;
    localparam logic [SCORE_W-1:0] CMAX     = {SCORE_W{1'b1}};
    localparam logic [SCORE_W-1:0] SINGLE_V = SCORE_W'(SINGLE_BET);
    localparam logic [SCORE_W-1:0] MAX_V    = SCORE_W'(MAX_BET);
    localparam logic [SCORE_W-1:0] INIT_V   = SCORE_W'(INIT_CREDIT);
    localparam logic [SCORE_W-1:0] COIN_V   = SCORE_W'(COIN_VALUE);

    state_e             state_q;
    logic [SCORE_W-1:0] credit_q, credit_d;
    logic [SCORE_W-1:0] bet_amount_q;
    logic [SCORE_W-1:0] last_payout_q;
    logic               spin_start_q, busy_q, insufficient_q, win_pulse_q;

    logic [SCORE_W-1:0] bet_sel;
    logic               bet_ok;
    logic               bet_take;
    logic [SCORE_W-1:0] base;
    logic [SCORE_W-1:0] pay_add;
    logic [SCORE_W-1:0] coin_add;
    logic [PW-1:0]      prod;
    logic [SCORE_W-1:0] payout_clamped;

    // Bet decision, debit and payout product; the compare sees the
    // pre-coin credit so a same-cycle coin cannot rescue a short bet.
    always_comb begin
        bet_sel  = max_sel ? MAX_V : SINGLE_V;
        bet_ok   = (credit_q >= bet_sel);
        bet_take = (state_q == IDLE) && bet_req && bet_ok;
        // Subtraction cannot underflow: only taken when bet_ok.
        base     = credit_q - (bet_take ? bet_sel : '0);
        pay_add  = (state_q == PAYOUT) ? last_payout_q : '0;
        coin_add = coin_in ? COIN_V : '0;
        prod     = PW'(bet_amount_q) * PW'(payout_mult);
        payout_clamped = (prod > PW'(CMAX)) ? CMAX : prod[SCORE_W-1:0];
    end

    // Debit, payout and coin fold into one saturating update.
    sat_adder #(.W(SCORE_W)) u_credit_add (
        .a_i   (base),
        .b_i   (pay_add),
        .c_i   (coin_add),
        .sum_o (credit_d)
    );

    // Round FSM with registered credit, latches and one-cycle pulses.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q        <= IDLE;
            credit_q       <= INIT_V;
            bet_amount_q   <= '0;
            last_payout_q  <= '0;
            spin_start_q   <= 1'b0;
            busy_q         <= 1'b0;
            insufficient_q <= 1'b0;
            win_pulse_q    <= 1'b0;
        end else begin
            credit_q       <= credit_d;
            spin_start_q   <= 1'b0;
            insufficient_q <= 1'b0;
            win_pulse_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bet_req) begin
                        if (bet_ok) begin
                            bet_amount_q <= bet_sel;
                            spin_start_q <= 1'b1;
                            busy_q       <= 1'b1;
                            state_q      <= SPIN;
                        end else begin
                            insufficient_q <= 1'b1;
                        end
                    end
                end
                SPIN: begin
                    if (spin_done) begin
                        last_payout_q <= payout_clamped;
                        state_q       <= PAYOUT;
                    end
                end
                PAYOUT: begin
                    win_pulse_q <= (last_payout_q != '0);
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign credit       = credit_q;
    assign bet_amount   = bet_amount_q;
    assign last_payout  = last_payout_q;
    assign spin_start   = spin_start_q;
    assign busy         = busy_q;
    assign insufficient = insufficient_q;
    assign win_pulse    = win_pulse_q;

endmodule

// File: tb/tb_slot_credit_ctrl.sv
// Directed bench for slot_credit_ctrl: vector table plus corner sequences.
module tb_slot_credit_ctrl;

    localparam int CMAX = 131071;

    logic        clk = 1'b0;
    logic        resetn;
    logic        bet_req, max_sel, coin_in, spin_done;
    logic [3:0]  payout_mult;
    logic [16:0] credit, bet_amount, last_payout;
    logic        spin_start, busy, insufficient, win_pulse;

    int checks   = 0;
    int failures = 0;
    int exp_credit;

    slot_credit_ctrl dut (
        .clk          (clk),
        .resetn       (resetn),
        .bet_req      (bet_req),
        .max_sel      (max_sel),
        .coin_in      (coin_in),
        .spin_done    (spin_done),
        .payout_mult  (payout_mult),
        .credit       (credit),
        .bet_amount   (bet_amount),
        .spin_start   (spin_start),
        .busy         (busy),
        .insufficient (insufficient),
        .win_pulse    (win_pulse),
        .last_payout  (last_payout)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic       br, ms, coin, sd;
        logic [3:0] mult;
        int         credit, bet;
        logic       ss, busy, ins, win;
        int         lp;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bet_req = 0; max_sel = 0; coin_in = 0; spin_done = 0; payout_mult = 0;
    endtask

    // Full round with no coins; reference credit tracked in exp_credit.
    task automatic round(input logic mx, input int mult);
        int b, pay;
        b = mx ? 5 : 1;
        bet_req = 1; max_sel = mx;
        tick();
        idle_inputs();
        exp_credit -= b;
        chk("round_debit", credit, exp_credit);
        chk("round_spin_start", spin_start, 1);
        spin_done = 1; payout_mult = mult[3:0];
        tick();
        idle_inputs();
        pay = b * mult;
        chk("round_last_payout", last_payout, pay);
        tick();
        exp_credit = (exp_credit + pay > CMAX) ? CMAX : exp_credit + pay;
        chk("round_credit", credit, exp_credit);
        chk("round_win", win_pulse, (pay != 0));
        chk("round_busy", busy, 0);
    endtask

    initial begin
        int guard;
        idle_inputs();
        resetn = 0;

        tbl[0]  = '{1,0,0,0,0,  99,1,1,1,0,0,0};
        tbl[1]  = '{0,0,0,0,0,  99,1,0,1,0,0,0};
        tbl[2]  = '{0,0,0,1,0,  99,1,0,1,0,0,0};
        tbl[3]  = '{0,0,0,0,0,  99,1,0,0,0,0,0};
        tbl[4]  = '{1,1,0,0,0,  94,5,1,1,0,0,0};
        tbl[5]  = '{1,0,0,0,0,  94,5,0,1,0,0,0};
        tbl[6]  = '{0,0,0,1,10, 94,5,0,1,0,0,50};
        tbl[7]  = '{0,0,0,0,0, 144,5,0,0,0,1,50};
        tbl[8]  = '{0,0,0,0,0, 144,5,0,0,0,0,50};
        tbl[9]  = '{0,0,1,0,0, 145,5,0,0,0,0,50};
        tbl[10] = '{1,0,1,0,0, 145,1,1,1,0,0,50};
        tbl[11] = '{0,0,0,1,15,145,1,0,1,0,0,15};
        tbl[12] = '{0,0,1,0,0, 161,1,0,0,0,1,15};
        tbl[13] = '{0,0,0,0,0, 161,1,0,0,0,0,15};

        #12;
        chk("rst_credit", credit, 100);
        chk("rst_bet", bet_amount, 0);
        chk("rst_lp", last_payout, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pulses", {spin_start, insufficient, win_pulse}, 0);
        @(negedge clk);
        resetn = 1;

        // Table of single-cycle vectors starting from reset credit 100.
        for (int i = 0; i < 14; i++) begin
            bet_req = tbl[i].br; max_sel = tbl[i].ms; coin_in = tbl[i].coin;
            spin_done = tbl[i].sd; payout_mult = tbl[i].mult;
            tick();
            idle_inputs();
            chk($sformatf("v%0d_credit", i), credit, tbl[i].credit);
            chk($sformatf("v%0d_bet", i), bet_amount, tbl[i].bet);
            chk($sformatf("v%0d_spin_start", i), spin_start, tbl[i].ss);
            chk($sformatf("v%0d_busy", i), busy, tbl[i].busy);
            chk($sformatf("v%0d_insufficient", i), insufficient, tbl[i].ins);
            chk($sformatf("v%0d_win", i), win_pulse, tbl[i].win);
            chk($sformatf("v%0d_last_payout", i), last_payout, tbl[i].lp);
        end
        exp_credit = 161;

        // Drain to 3 with losing rounds.
        while (exp_credit >= 8) round(1, 0);
        while (exp_credit > 3) round(0, 0);
        chk("drain_credit", credit, 3);

        // Max bet at 3 is refused.
        bet_req = 1; max_sel = 1;
        tick();
        idle_inputs();
        chk("insuf_pulse", insufficient, 1);
        chk("insuf_credit", credit, 3);
        chk("insuf_no_spin", spin_start, 0);
        chk("insuf_busy", busy, 0);
        tick();
        chk("insuf_one_cycle", insufficient, 0);
        chk("insuf_credit_hold", credit, 3);

        // Single bet at 3 is accepted.
        round(0, 0);
        chk("single_at_3", credit, 2);

        // Coins up to 10, then coin coincident with a single bet.
        for (int i = 0; i < 8; i++) begin
            coin_in = 1;
            tick();
        end
        coin_in = 0;
        chk("coin_to_10", credit, 10);
        bet_req = 1; coin_in = 1;
        tick();
        idle_inputs();
        chk("coin_bet_credit", credit, 10);
        chk("coin_bet_start", spin_start, 1);
        bet_req = 1; max_sel = 1;
        tick();
        idle_inputs();
        chk("spin_bet_ignored", credit, 10);
        chk("spin_bet_no_start", spin_start, 0);
        chk("spin_bet_no_insuf", insufficient, 0);
        spin_done = 1;
        tick();
        idle_inputs();
        tick();
        chk("coin_bet_round_end", credit, 10);
        exp_credit = 10;

        // Pump credit to the ceiling with winning max rounds.
        guard = 0;
        while (exp_credit != CMAX && guard < 3000) begin
            round(1, 15);
            guard++;
        end
        chk("pump_reached_max", credit, CMAX);

        // Payout of 5 plus coin at 131070 must clamp, not wrap.
        bet_req = 1;
        tick();
        idle_inputs();
        chk("sat_pre_credit", credit, 131070);
        spin_done = 1; payout_mult = 5;
        tick();
        idle_inputs();
        chk("sat_lp", last_payout, 5);
        coin_in = 1;
        tick();
        idle_inputs();
        chk("sat_credit", credit, CMAX);
        chk("sat_win", win_pulse, 1);

        // Reset in SPIN abandons the round.
        tick();
        @(negedge clk);
        resetn = 0;
        #2;
        resetn = 1;
        exp_credit = 100;
        max_sel = 1; bet_req = 1;
        tick();
        idle_inputs();
        chk("mid_spin_credit", credit, 95);
        #2;
        resetn = 0;
        #2;
        chk("mid_rst_credit", credit, 100);
        chk("mid_rst_busy", busy, 0);
        @(negedge clk);
        resetn = 1;
        spin_done = 1; payout_mult = 15;
        tick();
        idle_inputs();
        chk("stray_done_lp", last_payout, 0);
        tick();
        chk("stray_done_credit", credit, 100);
        chk("stray_done_win", win_pulse, 0);
        chk("stray_done_busy", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
